// File: rtl/easy_fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one producer at a time a burst of up to
// BURST_MAX whole blocks into a shared wide-input FIFO write port.
module easy_fifo_wr_arbiter #(
    parameter int DATAWIDTH = 192,
    parameter int IN_SIZE   = 6,
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*DATAWIDTH*IN_SIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [DATAWIDTH*IN_SIZE-1:0]          fifo_din,
    output logic                                  fifo_din_valid,
    input  logic                                  fifo_full,
    input  logic                                  fifo_almost_full,
    output logic [ID_WIDTH-1:0]                   grant_id,
    output logic                                  busy
);
    localparam int BLK_W = DATAWIDTH * IN_SIZE;
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_nxt, grant_nxt, sel_id;
    logic [CNT_W-1:0]    burst_cnt, cnt_nxt;
    logic                found, g_valid, xfer, last_blk;
    logic [NUM_REQ-1:0]  ready_c;
    logic [BLK_W-1:0]    din_c;
    logic                din_valid_c;
    int unsigned         idx;

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        sel_id = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                sel_id = ID_WIDTH'(idx);
            end
        end
    end

    assign g_valid  = req_valid[grant_id];
    assign xfer     = (state == BURST) && g_valid && !fifo_full;
    assign last_blk = (burst_cnt == CNT_W'(BURST_MAX - 1));

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_id;
        rr_ptr_nxt  = rr_ptr;
        cnt_nxt     = burst_cnt;
        ready_c     = '0;
        din_c       = '0;
        din_valid_c = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BURST;
                    grant_nxt = sel_id;
                    cnt_nxt   = '0;
                end
            end
            BURST: begin
                din_c             = req_data[int'(grant_id)*BLK_W +: BLK_W];
                ready_c[grant_id] = !fifo_full;
                din_valid_c       = xfer;
                if (xfer)
                    cnt_nxt = burst_cnt + CNT_W'(1);
                // A write under almost_full fills the FIFO, so yield the grant.
                if ((xfer && (last_blk || fifo_almost_full)) || !g_valid) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_id  <= grant_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    // Reset masks outputs immediately so a burst cut by reset issues nothing.
    assign req_ready      = rst ? '0 : ready_c;
    assign fifo_din       = rst ? '0 : din_c;
    assign fifo_din_valid = din_valid_c && !rst;
    assign busy           = (state == BURST) && !rst;

endmodule

// File: tb/tb_easy_fifo_wr_arbiter.sv
// Randomized bench for easy_fifo_wr_arbiter: a per-cycle reference model feeds
// expected control and block queues that a negedge monitor drains and compares.
module tb_easy_fifo_wr_arbiter;
    localparam int DATAWIDTH = 192;
    localparam int IN_SIZE   = 6;
    localparam int NUM_REQ   = 4;
    localparam int BURST_MAX = 4;
    localparam int ID_W      = $clog2(NUM_REQ);
    localparam int BLK_W     = DATAWIDTH * IN_SIZE;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*BLK_W-1:0]  req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [BLK_W-1:0]          fifo_din;
    logic                      fifo_din_valid;
    logic                      fifo_full;
    logic                      fifo_almost_full;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;

    easy_fifo_wr_arbiter #(
        .DATAWIDTH(DATAWIDTH), .IN_SIZE(IN_SIZE), .NUM_REQ(NUM_REQ), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_din(fifo_din), .fifo_din_valid(fifo_din_valid),
        .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_REQ-1:0] rdy;
        logic               vld;
        logic               bsy;
        logic [ID_W-1:0]    gid;
        logic               idle;
    } ctl_t;

    ctl_t              ctl_q[$];
    logic [BLK_W-1:0]  blk_q[$];
    int                tests = 0;
    int                fails = 0;
    bit                done  = 1'b0;

    // Producer side: current block and number of blocks still to send.
    logic [BLK_W-1:0]  cur_blk[NUM_REQ];
    int                rem[NUM_REQ];
    int                pop_id = -1;

    // Reference model: who holds the grant, where the search starts, blocks sent.
    bit m_busy = 0, n_busy = 0;
    int m_owner = 0, n_owner = 0;
    int m_ptr = 0, n_ptr = 0;
    int m_sent = 0, n_sent = 0;

    function automatic logic [BLK_W-1:0] mk_blk();
        logic [BLK_W-1:0] b;
        for (int w = 0; w < BLK_W / 32; w++) b[w*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input bit r, input int p_en, input int p_full, input int p_af);
        ctl_t rec;
        bit   found, xfer;
        int   idx;
        @(posedge clk);
        m_busy = n_busy; m_owner = n_owner; m_ptr = n_ptr; m_sent = n_sent;
        if (pop_id >= 0) begin
            rem[pop_id]--;
            cur_blk[pop_id] = mk_blk();
            pop_id = -1;
        end
        #1;
        rst = r;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = (rem[i] > 0) && ($urandom_range(0, 99) < p_en);
            req_data[i*BLK_W +: BLK_W] = cur_blk[i];
        end
        fifo_full        = $urandom_range(0, 99) < p_full;
        fifo_almost_full = $urandom_range(0, 99) < p_af;

        rec.rdy = '0; rec.vld = 1'b0; rec.bsy = 1'b0; rec.idle = 1'b0;
        rec.gid = ID_W'(m_owner);
        n_busy = m_busy; n_owner = m_owner; n_ptr = m_ptr; n_sent = m_sent;
        if (r) begin
            rec.idle = 1'b1;
            n_busy = 0; n_owner = 0; n_ptr = 0; n_sent = 0;
        end else if (!m_busy) begin
            rec.idle = 1'b1;
            found = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (!found && req_valid[idx]) begin
                    found = 1; n_owner = idx;
                end
            end
            if (found) begin n_busy = 1; n_sent = 0; end
        end else begin
            rec.bsy = 1'b1;
            if (!fifo_full) rec.rdy[m_owner] = 1'b1;
            xfer = req_valid[m_owner] && !fifo_full;
            rec.vld = xfer;
            if (xfer) begin
                blk_q.push_back(cur_blk[m_owner]);
                pop_id = m_owner;
                n_sent = m_sent + 1;
            end
            if ((xfer && (n_sent == BURST_MAX || fifo_almost_full)) || !req_valid[m_owner]) begin
                n_busy = 0;
                n_ptr  = (m_owner + 1) % NUM_REQ;
            end
        end
        ctl_q.push_back(rec);
    endtask

    task automatic load(input int r0, input int r1, input int r2, input int r3);
        rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0;
        fifo_full = 1'b0; fifo_almost_full = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin cur_blk[i] = mk_blk(); rem[i] = 0; end
        repeat (3) step(1, 100, 0, 0);
        // Single producer with six blocks: burst of four, idle gap, then two.
        load(6, 0, 0, 0);
        repeat (12) step(0, 100, 0, 0);
        // Everyone busy: rotating grants of four.
        load(20, 20, 20, 20);
        repeat (30) step(0, 100, 0, 0);
        // Backpressure: three full cycles inside a burst.
        repeat (2) step(0, 100, 0, 0);
        repeat (3) step(0, 100, 100, 0);
        repeat (8) step(0, 100, 0, 0);
        // almost_full yields grants early.
        repeat (20) step(0, 100, 0, 40);
        // Reset mid-burst, then recover.
        repeat (2) step(0, 100, 0, 0);
        repeat (2) step(1, 100, 0, 0);
        repeat (20) step(0, 100, 0, 0);
        // Fully random traffic, flags and valid drops.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (rem[i] == 0) rem[i] = $urandom_range(0, 6);
            repeat (40) step($urandom_range(0, 199) == 0, 70, 25, 20);
        end
        // Drain everything still pending.
        repeat (200) step(0, 100, 0, 0);
        done = 1'b1;
    end

    always @(negedge clk) begin
        ctl_t r;
        logic [BLK_W-1:0] e;
        if (ctl_q.size() > 0) begin
            r = ctl_q.pop_front();
            check("busy", busy, r.bsy);
            check("req_ready", req_ready, r.rdy);
            check("req_ready_onehot0", $onehot0(req_ready), 1);
            check("fifo_din_valid", fifo_din_valid, r.vld);
            check("grant_id", grant_id, r.gid);
            if (r.idle) check("fifo_din_zero_idle", (fifo_din == '0), 1);
        end
        if (fifo_din_valid) begin
            tests++;
            if (blk_q.size() == 0) begin
                fails++;
                $display("FAIL block_unexpected at %0t: got low %0h expected none", $time, fifo_din[63:0]);
            end else begin
                e = blk_q.pop_front();
                if (fifo_din != e) begin
                    fails++;
                    $display("FAIL block_data at %0t: got low %0h expected low %0h",
                             $time, fifo_din[63:0], e[63:0]);
                end
            end
        end
        if (done) begin
            check("blocks_left_undelivered", blk_q.size(), 0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

endmodule

// File: doc/easy_fifo_wr_arbiter.md
# easy_fifo_wr_arbiter

Round-robin write arbiter that shares one wide-input `easy_fifo` write port among `NUM_REQ` producers. Each producer offers whole `IN_SIZE`-word blocks. The arbiter grants one producer at a time for a bounded burst and forwards its blocks to the FIFO's `din`/`din_valid`. It honours the FIFO's `full`/`almost_full` flags so no block is ever dropped.

## Interface
- `DATAWIDTH`, 192: width of one FIFO word.
- `IN_SIZE`, 6: words per block; must match the FIFO's `IN_SIZE`.
- `NUM_REQ`, 4: number of producers, ≥2.
- `BURST_MAX`, 4: maximum blocks per grant, ≥1.
- `ID_WIDTH`, `$clog2(NUM_REQ)` (localparam).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  `NUM_REQ`  bit i: producer i offers a block.
- `req_data`  in  `NUM_REQ*DATAWIDTH*IN_SIZE`  producer i's block occupies slice `[i*DATAWIDTH*IN_SIZE +: DATAWIDTH*IN_SIZE]`.
- `req_ready`  out  `NUM_REQ`  bit i: producer i's block is accepted this cycle.
- `fifo_din`  out  `DATAWIDTH*IN_SIZE`  block to the FIFO `din`.
- `fifo_din_valid`  out  1  to the FIFO `din_valid`.
- `fifo_full`  in  1  from the FIFO `full`.
- `fifo_almost_full`  in  1  from the FIFO `almost_full`.
- `grant_id`  out  `ID_WIDTH`  index of the producer currently granted.
- `busy`  out  1  high while in the BURST state.

## Operation
- Registered state: `state` (IDLE/BURST), `grant_id`, `rr_ptr` (`ID_WIDTH` bits), `burst_cnt` (`$clog2(BURST_MAX+1)` bits).
- **IDLE**
  - Outputs: `req_ready`=0, `fifo_din_valid`=0, `fifo_din`=0.
  - If any `req_valid` bit is set, select the first set index searching upward from `rr_ptr`, wrapping from `NUM_REQ-1` to 0.
  - On selection: load `grant_id`, clear `burst_cnt`, go to BURST.
  - If no bit is set, stay in IDLE.
- **BURST** (g = `grant_id`)
  - `fifo_din` = slice g of `req_data`.
  - `req_ready[g]` = `!fifo_full`; all other `req_ready` bits are 0.
  - `fifo_din_valid` = `req_valid[g] && !fifo_full`.
  - Transfer = `req_valid[g] && !fifo_full`; each transfer increments `burst_cnt`.
- **Exit BURST → IDLE** on any of the following:
  - a transfer with `burst_cnt == BURST_MAX-1`;
  - a transfer while `fifo_almost_full`=1, since the FIFO is now full and the grant is yielded;
  - `req_valid[g]`=0 in a cycle, with no transfer that cycle.
- On exit, `rr_ptr` ← g+1, wrapping from `NUM_REQ-1` to 0.
- `fifo_full`=1 with `req_valid[g]`=1 is a stall: hold BURST, no transfer, `burst_cnt` unchanged.
- Producers change `req_data` only after a cycle in which their `req_ready` bit was 1, or while their `req_valid` bit is 0.
- The arbiter never asserts `fifo_din_valid` while `fifo_full`=1, so the FIFO's internal full-drop path is never exercised.

## Timing
- **Reset** (`rst`=1 at an edge): state=IDLE, `rr_ptr`=0, `grant_id`=0, `burst_cnt`=0.
  - Outputs during and after reset: `req_ready`=0, `fifo_din_valid`=0, `fifo_din`=0, `busy`=0.
  - Reset mid-burst abandons the grant. No partial block is issued; the FIFO sees `din_valid`=0 in every reset cycle.
- **Arbitration latency:** `req_valid` sampled in IDLE at edge t → BURST from t; earliest transfer in cycle t+1.
- **Inter-grant gap:** at least one IDLE cycle between consecutive grants, so maximum throughput is `BURST_MAX` blocks per `BURST_MAX`+1 cycles.
- **Outputs:** all are combinational from registered state plus `req_valid[g]`/`fifo_full`; there is no combinational path from `req_data` to control signals.
- **FIFO flag timing:** the FIFO flags are registered-count based, so `fifo_full` reflects writes up to the previous edge. This is correct because `full` and `count_num` in the FIFO update on the same edge as the write.

## Test plan
- **Single producer, BURST_MAX=4.**
  - Stimulus: `req_valid`=4'b0001 held, 6 blocks queued, FIFO never full.
  - Required: transfers at cycles 1–4, IDLE at cycle 5, transfers at 6–7; `grant_id`=0 throughout.
- **All four producers valid continuously.**
  - Required: grant order 0,1,2,3,0.
  - Required: exactly 4 blocks per grant; `req_ready` one-hot or zero every cycle.
- **Backpressure.**
  - Stimulus: `fifo_full` forced to 1 for 3 cycles mid-burst.
  - Required: `fifo_din_valid`=0 and `req_ready`=0 during those cycles; `burst_cnt` held; the burst resumes and completes 4 blocks total.
- **almost_full early exit.**
  - Stimulus: `fifo_almost_full`=1 on the 2nd transfer of producer 1.
  - Required: IDLE next cycle, `rr_ptr`=2, burst length 2.
- **Producer drops valid after 1 block.**
  - Stimulus: producer 3 (`rr_ptr`=3) drops `req_valid` after 1 block.
  - Required: IDLE, then `rr_ptr`=0 (wrap), and the next grant goes to the lowest valid index ≥0.
- **End-to-end with reset.**
  - Stimulus: arbiter connected to `easy_fifo` (SIZE=6, IN_SIZE=6); `rst` asserted mid-burst.
  - Required: outputs are at reset values the same cycle; no block is written during reset.
  - Required: after release, the data read from the FIFO matches the producer order exactly, with no loss or duplication.
